// File: rtl/spi_byte_sequencer_pkg.sv
// Shared definitions for the SPI byte sequencer.
//   SpiDw       : byte width exchanged with the 8-bit SPI master
//   seq_state_e : sequencer FSM states (3-bit encoding)
//   max_u       : constant-foldable maximum, used to size the shared timer
package spi_byte_sequencer_pkg;

  localparam int unsigned SpiDw = 8;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLoad    = 3'd1,
    StWaitLo  = 3'd2,
    StWaitHi  = 3'd3,
    StCapture = 3'd4,
    StGap     = 3'd5
  } seq_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_byte_fifo.sv
// Synchronous FIFO with first-word-fall-through read data.
// Ports:
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   push/wdata : write request and data; ignored while full
//   pop        : read request; ignored while empty; rdata shows the head entry
//   full/empty : occupancy flags
//   level      : occupancy, 0..DEPTH
module spi_byte_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == (PtrW + 1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (do_push && !do_pop) level_d = level_q + (PtrW + 1)'(1);
    if (!do_push && do_pop) level_d = level_q - (PtrW + 1)'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: entries are only read once the level covers them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/spi_byte_sequencer.sv
// Upstream feeder for the 8-bit SPI master. Queues outgoing bytes, launches one master transfer
// per byte, watches cs to detect end of transfer, captures the returned byte and enforces an
// idle gap between transfers.
// Ports:
//   clk, reset                 : rising-edge clock, asynchronous active-high reset
//   tx_data/tx_valid/tx_ready  : outgoing byte stream (accepted on tx_valid && tx_ready)
//   rx_data/rx_valid/rx_ready  : received byte holding register (cleared on rx_valid && rx_ready)
//   spi_enable/spi_data_in     : drive the master's spi_enable and data_in
//   spi_cs/spi_data_out        : master's cs (active low) and data_out
//   busy                       : FSM active or bytes queued
//   fifo_level                 : TX FIFO occupancy
//   rx_overrun/timeout_err     : sticky errors, cleared by err_clr
module spi_byte_sequencer
  import spi_byte_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned CS_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SpiDw-1:0]         tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic [SpiDw-1:0]         rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic                     spi_enable,
  output logic [SpiDw-1:0]         spi_data_in,
  input  logic                     spi_cs,
  input  logic [SpiDw-1:0]         spi_data_out,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     rx_overrun,
  output logic                     timeout_err,
  input  logic                     err_clr
);

  // One timer serves both the cs timeout and the inter-byte gap.
  localparam int unsigned TimerW = $clog2(max_u(CS_TIMEOUT, GAP_CYCLES + 1)) + 1;

  seq_state_e        state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              cs_q;
  logic [SpiDw-1:0]  data_in_q, data_in_d;
  logic [SpiDw-1:0]  rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              overrun_q, overrun_d;
  logic              timeout_q, timeout_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [SpiDw-1:0]  fifo_rdata;
  logic              capture, timeout_set, rx_accept;

  assign tx_ready  = !fifo_full;
  assign fifo_push = tx_valid && tx_ready;

  spi_byte_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SpiDw)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (tx_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Decoded from the state register so an asynchronous reset drops it at once.
  assign spi_enable  = (state_q == StLoad) || (state_q == StWaitLo) || (state_q == StWaitHi);
  assign spi_data_in = data_in_q;
  assign busy        = (state_q != StIdle) || !fifo_empty;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overrun  = overrun_q;
  assign timeout_err = timeout_q;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    data_in_d   = data_in_q;
    fifo_pop    = 1'b0;
    capture     = 1'b0;
    timeout_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          data_in_d = fifo_rdata;
          state_d   = StLoad;
        end
      end
      StLoad: begin
        timer_d = '0;
        state_d = StWaitLo;
      end
      StWaitLo: begin
        timer_d = timer_q + TimerW'(1);
        if (!spi_cs) begin
          state_d = StWaitHi;
        end else if (timer_q == TimerW'(CS_TIMEOUT - 1)) begin
          // Master never started: drop the byte and still honour the gap.
          timeout_set = 1'b1;
          timer_d     = '0;
          state_d     = StGap;
        end
      end
      StWaitHi: begin
        if (!cs_q && spi_cs) state_d = StCapture;
      end
      StCapture: begin
        capture = 1'b1;
        timer_d = '0;
        state_d = StGap;
      end
      StGap: begin
        timer_d = timer_q + TimerW'(1);
        if (timer_q == TimerW'(GAP_CYCLES)) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // RX holding register and sticky errors; err_clr wins over a same-cycle set.
  always_comb begin
    rx_accept  = rx_valid_q && rx_ready;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    timeout_d  = timeout_q;
    if (rx_accept) rx_valid_d = 1'b0;
    if (capture) begin
      rx_data_d  = spi_data_out;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rx_ready) overrun_d = 1'b1;
    end
    if (timeout_set) timeout_d = 1'b1;
    if (err_clr) begin
      overrun_d = 1'b0;
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      cs_q       <= 1'b1;
      data_in_q  <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      cs_q       <= spi_cs;
      data_in_q  <= data_in_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_spi_byte_sequencer.sv
module tb_spi_byte_sequencer;

  localparam int unsigned Depth     = 8;
  localparam int unsigned GapCycles = 4;
  localparam int unsigned CsTimeout = 64;

  localparam int SelEn      = 0;
  localparam int SelRxValid = 1;
  localparam int SelBusy    = 2;
  localparam int SelTimeout = 3;
  localparam int SelCs      = 4;

  logic       clk, reset;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       spi_enable;
  logic [7:0] spi_data_in;
  logic       spi_cs;
  logic [7:0] spi_data_out;
  logic       busy;
  logic [3:0] fifo_level;
  logic       rx_overrun, timeout_err, err_clr;

  spi_byte_sequencer #(
    .DEPTH      (Depth),
    .GAP_CYCLES (GapCycles),
    .CS_TIMEOUT (CsTimeout)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .spi_enable   (spi_enable),
    .spi_data_in  (spi_data_in),
    .spi_cs       (spi_cs),
    .spi_data_out (spi_data_out),
    .busy         (busy),
    .fifo_level   (fifo_level),
    .rx_overrun   (rx_overrun),
    .timeout_err  (timeout_err),
    .err_clr      (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_tx [$];
  logic [7:0] exp_rx [$];

  // Master model: cs low after 3 enabled cycles, 16 cycles low, returns ~data_in.
  logic       no_cs;
  int         m_phase, m_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase      <= 0;
      m_cnt        <= 0;
      spi_cs       <= 1'b1;
      spi_data_out <= 8'h00;
    end else begin
      case (m_phase)
        0: begin
          if (spi_enable && !no_cs) begin
            if (m_cnt == 2) begin
              spi_cs  <= 1'b0;
              m_cnt   <= 0;
              m_phase <= 1;
            end else begin
              m_cnt <= m_cnt + 1;
            end
          end else begin
            m_cnt <= 0;
          end
        end
        1: begin
          if (m_cnt == 15) begin
            spi_cs       <= 1'b1;
            spi_data_out <= ~spi_data_in;
            m_cnt        <= 0;
            m_phase      <= 2;
          end else begin
            m_cnt <= m_cnt + 1;
          end
        end
        default: begin
          if (!spi_enable) m_phase <= 0;
        end
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      SelEn:      return spi_enable;
      SelRxValid: return rx_valid;
      SelBusy:    return busy;
      SelTimeout: return timeout_err;
      SelCs:      return spi_cs;
      default:    return 1'b0;
    endcase
  endfunction

  task automatic wait_until(input string name, input int sel, input logic val, input int limit);
    int n = 0;
    while (sig(sel) !== val && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (sig(sel) !== val) begin
      errors++;
      $display("FAIL %s: timed out after %0d cycles, got %b required %b", name, n, sig(sel), val);
    end
  endtask

  // Push one byte; the expected master byte and (optionally) RX byte go to the scoreboard.
  task automatic push(input logic [7:0] b, input logic want_rx, input logic [7:0] rx_exp);
    int n = 0;
    exp_tx.push_back(b);
    if (want_rx) exp_rx.push_back(rx_exp);
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!tx_ready) begin
      checks++;
      errors++;
      $display("FAIL push_ready: tx_ready got 0 required 1 after %0d cycles", n);
    end
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  // Scoreboard monitor plus enable run-length measurement, sampled on the falling edge.
  int   low_run, high_run, last_low_run, last_high_run;
  logic en_prev;
  initial begin
    low_run = 0; high_run = 0; last_low_run = 0; last_high_run = 0; en_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        en_prev  = 1'b0;
        low_run  = 0;
        high_run = 0;
      end else begin
        if (spi_enable && !en_prev) begin
          if (exp_tx.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected: got 0x%0h required no transfer", spi_data_in);
          end else begin
            check("tx_byte", {24'h0, spi_data_in}, {24'h0, exp_tx.pop_front()});
          end
        end
        if (rx_valid && rx_ready) begin
          if (exp_rx.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected: got 0x%0h required no byte", rx_data);
          end else begin
            check("rx_byte", {24'h0, rx_data}, {24'h0, exp_rx.pop_front()});
          end
        end
        if (spi_enable) begin
          if (!en_prev) begin
            last_low_run = low_run;
            low_run      = 0;
          end
          high_run++;
        end else begin
          if (en_prev) begin
            last_high_run = high_run;
            high_run      = 0;
          end
          low_run++;
        end
        en_prev = spi_enable;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_rx;
    logic [3:0] exp_level;
    logic       exp_ready;
  } vec_t;

  vec_t vecs [9];

  initial begin
    // FIFO level after each accept: the first byte is popped straight away, the rest
    // queue up behind the running transfer until the FIFO is full.
    vecs[0] = '{8'h01, 8'hFE, 4'd1, 1'b1};
    vecs[1] = '{8'h23, 8'hDC, 4'd1, 1'b1};
    vecs[2] = '{8'h45, 8'hBA, 4'd2, 1'b1};
    vecs[3] = '{8'h67, 8'h98, 4'd3, 1'b1};
    vecs[4] = '{8'h89, 8'h76, 4'd4, 1'b1};
    vecs[5] = '{8'hAB, 8'h54, 4'd5, 1'b1};
    vecs[6] = '{8'hCD, 8'h32, 4'd6, 1'b1};
    vecs[7] = '{8'hEF, 8'h10, 4'd7, 1'b1};
    vecs[8] = '{8'hF0, 8'h0F, 4'd8, 1'b0};

    reset = 1'b1; tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0; err_clr = 1'b0;
    no_cs = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;

    check("rst_tx_ready", {31'h0, tx_ready}, 32'd1);
    check("rst_rx_valid", {31'h0, rx_valid}, 32'd0);
    check("rst_spi_enable", {31'h0, spi_enable}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_level", {28'h0, fifo_level}, 32'd0);
    check("rst_errors", {30'h0, rx_overrun, timeout_err}, 32'd0);
    check("rst_rx_data", {24'h0, rx_data}, 32'd0);
    check("rst_data_in", {24'h0, spi_data_in}, 32'd0);

    // 1: single byte latency, returned byte, inter-byte gap.
    @(posedge clk);
    #1;
    exp_tx.push_back(8'hA5);
    exp_rx.push_back(8'h5A);
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    check("t1_level_after_push", {28'h0, fifo_level}, 32'd1);
    check("t1_enable_cycle1", {31'h0, spi_enable}, 32'd0);
    @(posedge clk);
    #1;
    check("t1_enable_cycle2", {31'h0, spi_enable}, 32'd1);
    check("t1_data_in", {24'h0, spi_data_in}, 32'hA5);
    check("t1_busy", {31'h0, busy}, 32'd1);
    push(8'h3C, 1'b1, 8'hC3);
    wait_until("t1_rx_valid", SelRxValid, 1'b1, 200);
    check("t1_rx_data", {24'h0, rx_data}, 32'h5A);
    rx_ready = 1'b1;
    wait_until("t1_second_enable", SelEn, 1'b1, 100);
    @(negedge clk);
    #1;
    // Low between transfers: CAPTURE + GAP (GapCycles+1) + IDLE.
    check("t1_gap_cycles", last_low_run, GapCycles + 3);
    wait_until("t1_idle", SelBusy, 1'b0, 300);
    repeat (3) @(posedge clk);
    #1;
    check("t1_tx_drained", exp_tx.size(), 32'd0);
    check("t1_rx_drained", exp_rx.size(), 32'd0);

    // 2: fill the FIFO behind a running transfer, then drain in order.
    for (int i = 0; i < 9; i++) begin
      push(vecs[i].data, 1'b1, vecs[i].exp_rx);
      check($sformatf("t2_level_%0d", i), {28'h0, fifo_level}, {28'h0, vecs[i].exp_level});
      check($sformatf("t2_ready_%0d", i), {31'h0, tx_ready}, {31'h0, vecs[i].exp_ready});
      if (i == 0) wait_until("t2_first_enable", SelEn, 1'b1, 20);
    end
    wait_until("t2_idle", SelBusy, 1'b0, 2000);
    repeat (3) @(posedge clk);
    #1;
    check("t2_tx_drained", exp_tx.size(), 32'd0);
    check("t2_rx_drained", exp_rx.size(), 32'd0);
    check("t2_no_overrun", {31'h0, rx_overrun}, 32'd0);

    // 3: unread byte overwritten -> overrun, then cleared by err_clr.
    rx_ready = 1'b0;
    push(8'h12, 1'b0, 8'h00);
    push(8'h34, 1'b1, 8'hCB);
    wait_until("t3_idle", SelBusy, 1'b0, 500);
    check("t3_overrun", {31'h0, rx_overrun}, 32'd1);
    check("t3_rx_valid", {31'h0, rx_valid}, 32'd1);
    check("t3_rx_data", {24'h0, rx_data}, 32'hCB);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("t3_overrun_cleared", {31'h0, rx_overrun}, 32'd0);
    rx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t3_rx_drained", exp_rx.size(), 32'd0);

    // 4: master never drops cs -> timeout, byte dropped, next byte still goes out.
    no_cs = 1'b1;
    push(8'h77, 1'b0, 8'h00);
    push(8'h66, 1'b1, 8'h99);
    wait_until("t4_timeout", SelTimeout, 1'b1, 300);
    no_cs = 1'b1;
    no_cs = 1'b0;
    @(negedge clk);
    #1;
    // Enable high for LOAD plus CsTimeout cycles of WAIT_LO.
    check("t4_enable_cycles", last_high_run, CsTimeout + 1);
    check("t4_enable_dropped", {31'h0, spi_enable}, 32'd0);
    wait_until("t4_idle", SelBusy, 1'b0, 500);
    repeat (3) @(posedge clk);
    #1;
    check("t4_tx_drained", exp_tx.size(), 32'd0);
    check("t4_rx_drained", exp_rx.size(), 32'd0);
    check("t4_timeout_sticky", {31'h0, timeout_err}, 32'd1);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("t4_timeout_cleared", {31'h0, timeout_err}, 32'd0);

    // 5: asynchronous reset while waiting for cs to rise.
    push(8'h5A, 1'b0, 8'h00);
    push(8'h5B, 1'b0, 8'h00);
    wait_until("t5_cs_low", SelCs, 1'b0, 50);
    repeat (2) @(posedge clk);
    #1;
    check("t5_pre_enable", {31'h0, spi_enable}, 32'd1);
    check("t5_pre_level", {28'h0, fifo_level}, 32'd1);
    reset = 1'b1;
    #1;
    check("t5_enable", {31'h0, spi_enable}, 32'd0);
    check("t5_level", {28'h0, fifo_level}, 32'd0);
    check("t5_tx_ready", {31'h0, tx_ready}, 32'd1);
    check("t5_busy", {31'h0, busy}, 32'd0);
    exp_tx.delete();
    exp_rx.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    push(8'hC3, 1'b1, 8'h3C);
    wait_until("t5_idle", SelBusy, 1'b0, 300);
    repeat (3) @(posedge clk);
    #1;
    check("t5_tx_drained", exp_tx.size(), 32'd0);
    check("t5_rx_drained", exp_rx.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
